// File: rtl/pll0_ctrl.sv
// Power-up / relock sequencer for the core0 PLL control pins.
// Optional build macro: PLL0_AUTO_BYPASS_EN (on lock timeout fall back to the reference clock).
module pll0_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_STABLE  = 64,
  parameter int         LOCK_TIMEOUT = 4096,
  parameter logic [1:0] DIV_RESET    = 2'b11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] div_req_i,
  input  logic       div_req_valid_i,
  output logic       div_req_ready_o,
  input  logic       lock_i,
  output logic       pll_rstn_o,
  output logic [1:0] pll_div_o,
  output logic       pll_bps_o,
  output logic       pll_ready_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    BYPASS    = 3'd4
  } state_t;

  localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_ALL = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_meta;
  logic          lock_s;

  assign state_o = state;

  // lock_i comes straight from the PLL analog block, so it is never used raw.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock_i;
      lock_s    <= lock_meta;
    end
  end

  // Outputs are registered alongside the state they belong to, so they track
  // the state register exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= HOLD;
      cnt             <= '0;
      pll_rstn_o      <= 1'b0;
      pll_div_o       <= DIV_RESET;
      pll_bps_o       <= 1'b0;
      pll_ready_o     <= 1'b0;
      timeout_o       <= 1'b0;
      div_req_ready_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      cnt       <= (&cnt) ? cnt : cnt + CW'(1);

      case (state)
        HOLD: begin
          if (cnt == RST_LAST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_rstn_o <= 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_o <= 1'b1;
            cnt       <= '0;
`ifdef PLL0_AUTO_BYPASS_EN
            state           <= BYPASS;
            pll_rstn_o      <= 1'b0;
            pll_bps_o       <= 1'b1;
            pll_ready_o     <= 1'b1;
            div_req_ready_o <= 1'b1;
`else
            state      <= HOLD;
            pll_rstn_o <= 1'b0;
`endif
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state           <= RUN;
            cnt             <= '0;
            pll_ready_o     <= 1'b1;
            div_req_ready_o <= 1'b1;
          end
        end

        // A divider request beats a simultaneous lock loss: the restart it
        // triggers covers the relock anyway.
        RUN, BYPASS: begin
          if (div_req_valid_i && div_req_ready_o) begin
            state           <= HOLD;
            cnt             <= '0;
            pll_div_o       <= div_req_i;
            pll_rstn_o      <= 1'b0;
            pll_bps_o       <= 1'b0;
            pll_ready_o     <= 1'b0;
            div_req_ready_o <= 1'b0;
          end else if (state == RUN && !lock_s) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            pll_ready_o     <= 1'b0;
            div_req_ready_o <= 1'b0;
          end
        end

        default: begin
          state           <= HOLD;
          cnt             <= '0;
          pll_rstn_o      <= 1'b0;
          pll_bps_o       <= 1'b0;
          pll_ready_o     <= 1'b0;
          div_req_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll0_ctrl.sv
// Directed, table-driven bench for pll0_ctrl; expectations are hand-computed cycle numbers.
// Follows PLL0_AUTO_BYPASS_EN for the lock-timeout outcome.
module tb_pll0_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] div_req_i = 2'b00;
  logic       div_req_valid_i = 1'b0;
  logic       div_req_ready_o;
  logic       lock_i = 1'b0;
  logic       pll_rstn_o;
  logic [1:0] pll_div_o;
  logic       pll_bps_o;
  logic       pll_ready_o;
  logic       timeout_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pll0_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .div_req_i       (div_req_i),
    .div_req_valid_i (div_req_valid_i),
    .div_req_ready_o (div_req_ready_o),
    .lock_i          (lock_i),
    .pll_rstn_o      (pll_rstn_o),
    .pll_div_o       (pll_div_o),
    .pll_bps_o       (pll_bps_o),
    .pll_ready_o     (pll_ready_o),
    .timeout_o       (timeout_o),
    .state_o         (state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       rst;
    logic       lock;
    logic [1:0] req;
    logic       valid;
    int         cycles;
    logic       rstn;
    logic [1:0] div;
    logic       bps;
    logic       ready;
    logic       tmo;
    logic       drr;
    logic [2:0] st;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i           = v.rst;
    lock_i          = v.lock;
    div_req_i       = v.req;
    div_req_valid_i = v.valid;
    repeat (v.cycles) tick();
  endtask

  task automatic doReset();
    rst_i           = 1'b1;
    lock_i          = 1'b0;
    div_req_i       = 2'b00;
    div_req_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    cyc   = 0;
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, "_rstn"},  int'(pll_rstn_o),      int'(v.rstn));
    checkOutput({tag, "_div"},   int'(pll_div_o),       int'(v.div));
    checkOutput({tag, "_bps"},   int'(pll_bps_o),       int'(v.bps));
    checkOutput({tag, "_ready"}, int'(pll_ready_o),     int'(v.ready));
    checkOutput({tag, "_tmo"},   int'(timeout_o),       int'(v.tmo));
    checkOutput({tag, "_drr"},   int'(div_req_ready_o), int'(v.drr));
    checkOutput({tag, "_state"}, int'(state_o),         int'(v.st));
  endtask

  initial begin
    int   rise_rstn;
    int   rise_rdy;
    int   div_bad;
    int   t0;
    vec_t rv;

    // {rst, lock, req, valid, cycles, rstn, div, bps, ready, tmo, drr, state}
    vecs[0]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1,  1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 15, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1,  1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1,  1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 63, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1,  1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1,  1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 1'b0, 16, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 2,  1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1,  1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[10] = '{1'b1, 1'b1, 2'b01, 1'b0, 1,  1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    // Power-up: reset values, lock at cycle 30, ready at 30+2+64+1.
    doReset();
    rv = '{1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    checkAll("reset", rv);
    rise_rstn = -1;
    rise_rdy  = -1;
    div_bad   = 0;
    while (cyc < 200 && rise_rdy < 0) begin
      if (pll_rstn_o && rise_rstn < 0) rise_rstn = cyc;
      if (pll_ready_o) rise_rdy = cyc;
      if (pll_div_o != 2'b11) div_bad++;
      if (cyc == 30) lock_i = 1'b1;
      if (rise_rdy < 0) tick();
    end
    checkOutput("powerup_rstn_rise", rise_rstn, 16);
    checkOutput("powerup_ready_rise", rise_rdy, 97);
    checkOutput("powerup_div_changes", div_bad, 0);

    // Divider change, same-code restart, resync latency, reset from STABLE.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i]);
    end
    rst_i = 1'b0;

    // Short lock glitch during STABLE, then a full debounce on the next lock.
    doReset();
    repeat (16) tick();
    checkOutput("glitch_wait_lock", int'(state_o), 1);
    lock_i = 1'b1;
    repeat (10) tick();
    checkOutput("glitch_stable", int'(state_o), 2);
    lock_i = 1'b0;
    repeat (2) tick();
    checkOutput("glitch_stable_late", int'(state_o), 2);
    tick();
    checkOutput("glitch_back_wait", int'(state_o), 1);
    checkOutput("glitch_no_ready", int'(pll_ready_o), 0);
    repeat (11) tick();
    lock_i   = 1'b1;
    rise_rdy = -1;
    while (cyc < 250 && rise_rdy < 0) begin
      if (pll_ready_o) rise_rdy = cyc;
      else tick();
    end
    checkOutput("glitch_relock_ready", rise_rdy, 107);

    // Lock loss in RUN: ready drops 3 cycles after lock_i, no reset pulse.
    t0     = cyc;
    lock_i = 1'b0;
    repeat (2) tick();
    checkOutput("loss_ready_before", int'(pll_ready_o), 1);
    tick();
    checkOutput("loss_ready_after", int'(pll_ready_o), 0);
    checkOutput("loss_state", int'(state_o), 1);
    checkOutput("loss_rstn", int'(pll_rstn_o), 1);
    tick();
    checkOutput("loss_rstn_next", int'(pll_rstn_o), 1);

    // Relock, then a request landing on the same edge the FSM sees lock loss.
    t0       = cyc;
    lock_i   = 1'b1;
    rise_rdy = -1;
    while (cyc < t0 + 150 && rise_rdy < 0) begin
      if (pll_ready_o) rise_rdy = cyc - t0;
      else tick();
    end
    checkOutput("relock_latency", rise_rdy, 67);
    lock_i = 1'b0;
    repeat (2) tick();
    checkOutput("race_ready_before", int'(pll_ready_o), 1);
    div_req_i       = 2'b10;
    div_req_valid_i = 1'b1;
    tick();
    div_req_valid_i = 1'b0;
    checkOutput("race_state", int'(state_o), 0);
    checkOutput("race_div", int'(pll_div_o), 2);
    checkOutput("race_ready", int'(pll_ready_o), 0);
    checkOutput("race_rstn", int'(pll_rstn_o), 0);

    // Lock never arrives: timeout pulse 16+4096 cycles after reset release.
    doReset();
    t0 = -1;
    while (cyc < 4400 && t0 < 0) begin
      if (timeout_o) t0 = cyc;
      else tick();
    end
    checkOutput("timeout_cycle", t0, 4112);
`ifdef PLL0_AUTO_BYPASS_EN
    rv = '{1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4};
    checkAll("bypass", rv);
    tick();
    checkOutput("bypass_tmo_width", int'(timeout_o), 0);
    checkOutput("bypass_stays", int'(state_o), 4);
    div_req_i       = 2'b00;
    div_req_valid_i = 1'b1;
    tick();
    div_req_valid_i = 1'b0;
    rv = '{1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    checkAll("bypass_exit", rv);
`else
    rv = '{1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    checkAll("retry", rv);
    tick();
    checkOutput("retry_tmo_width", int'(timeout_o), 0);
    rise_rstn = -1;
    while (cyc < 4300 && rise_rstn < 0) begin
      if (pll_rstn_o) rise_rstn = cyc;
      else tick();
    end
    checkOutput("retry_rstn_rise", rise_rstn, 4128);
    checkOutput("retry_div", int'(pll_div_o), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll0_ctrl.md
# pll0_ctrl

Sequencer that sits directly upstream of the core0 PLL and owns its control pins. It holds the PLL in power-down reset for a fixed time, programs the output divider, waits for a debounced lock, and only then reports the clock usable to the clock/reset logic. It also services run-time divider change requests and handles lock loss and lock timeout.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rstn_o` is held low per (re)start, ≥2.
- `LOCK_STABLE`, 64: consecutive synchronized-lock-high cycles required before ready, ≥1.
- `LOCK_TIMEOUT`, 4096: max cycles in WAIT_LOCK before timeout, > `LOCK_STABLE`.
- `DIV_RESET`, 2'b11: divider code driven after reset (÷8).
- `clk_i` in 1: reference clock (crystal, 25 MHz), never the PLL output.
- `rst_i` in 1: synchronous, active-high reset.
- `div_req_i` in 2: requested OD code.
- `div_req_valid_i` in 1: divider change request valid.
- `div_req_ready_o` out 1: request accepted this cycle when both high.
- `lock_i` in 1: raw PLL lock detect, asynchronous to `clk_i`.
- `pll_rstn_o` out 1: PLL reset, active-low (drives PLL `rstn_i`).
- `pll_div_o` out 2: PLL OD code.
- `pll_bps_o` out 1: PLL bypass.
- `pll_ready_o` out 1: PLL output valid for use.
- `timeout_o` out 1: one-cycle pulse on lock timeout.
- `state_o` out 3: current FSM state encoding, debug only.

## Operation
- `lock_i` passes through a 2-flop synchronizer (`lock_s`) before any use.
- States (encoding): HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, BYPASS=4.
- HOLD: `pll_rstn_o`=0, counter counts `RST_CYCLES`; on final count -> WAIT_LOCK, counter cleared.
- WAIT_LOCK: `pll_rstn_o`=1; `lock_s`=1 -> STABLE (counter cleared); counter reaching `LOCK_TIMEOUT`-1 with `lock_s`=0 -> timeout handling (see Configuration), `timeout_o` pulses.
- STABLE: counts consecutive `lock_s`=1 cycles; any `lock_s`=0 -> WAIT_LOCK with timeout counter cleared; count reaches `LOCK_STABLE` -> RUN.
- RUN: `pll_ready_o`=1; `lock_s` falls -> WAIT_LOCK, `pll_ready_o` drops next cycle, no reset pulse.
- BYPASS: `pll_bps_o`=1, `pll_rstn_o`=0, `pll_ready_o`=1 (reference clock passes through).
- `div_req_ready_o`=1 only in RUN and BYPASS. On accept: `pll_div_o` <= `div_req_i`, `pll_bps_o` <= 0, `pll_ready_o` <= 0, -> HOLD. Accept while `lock_s` falls in the same cycle: accept wins, -> HOLD.
- Request with code equal to current `pll_div_o` is still accepted and still restarts the PLL.
- `pll_div_o` changes only on accept or reset; it is stable throughout HOLD/WAIT_LOCK/STABLE.
- Single shared counter, width `$clog2(max(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT))+1`, saturating, cleared on every state change.

## Timing
- Reset values: `pll_rstn_o`=0, `pll_div_o`=`DIV_RESET`, `pll_bps_o`=0, `pll_ready_o`=0, `timeout_o`=0, `div_req_ready_o`=0, state HOLD. `rst_i` mid-operation returns to exactly these values the next edge.
- All outputs registered; output changes one cycle after the state transition causing it.
- `pll_rstn_o` low for exactly `RST_CYCLES` cycles per restart.
- Lock latency: `lock_i` rise to `pll_ready_o` rise = 2 (sync) + `LOCK_STABLE` + 1 cycles.
- Lock loss: `lock_i` fall to `pll_ready_o` fall = 2 + 1 cycles.
- Accept to `pll_ready_o` fall: 1 cycle.

## Configuration
- `PLL0_AUTO_BYPASS_EN` defined: timeout -> BYPASS; stays until a divider request or `rst_i`.
- Undefined: timeout -> HOLD (full retry, same `pll_div_o`), repeats indefinitely; BYPASS state unreachable, `pll_bps_o` constant 0.
- `timeout_o` pulses on every timeout in both builds.

## Test plan
- Reset release, `lock_i` rises at cycle 30, defaults -> `pll_rstn_o` low cycles 0–15, `pll_div_o`=2'b11, `pll_ready_o` rises at cycle 30+2+64+1=97.
- In RUN, request `div_req_i`=2'b01 -> accepted same cycle, `pll_ready_o` 0 next cycle, `pll_rstn_o` low 16 cycles, `pll_div_o`=2'b01 throughout, ready again after relock.
- `lock_i` glitch high 10 cycles during STABLE -> back to WAIT_LOCK, no `pll_ready_o`, full 64-cycle debounce on next lock.
- `lock_i` held 0, `LOCK_TIMEOUT`=4096 -> `timeout_o` one-cycle pulse; with `PLL0_AUTO_BYPASS_EN` `pll_bps_o`=1, `pll_ready_o`=1; without, `pll_rstn_o` low 16 cycles and retry.
- In RUN, `lock_i` drops -> `pll_ready_o` 0 after 3 cycles, `pll_rstn_o` stays 1; `rst_i` asserted in STABLE -> all outputs at reset values next cycle.
